// File: rtl/rr_trace_unpacker.sv
// Trace unpacker: splits a packed beat stream back into variable-length
// logging units (logb bitmap, loge bits, then the selected logb payloads).

package rr_trace_pkg;

    function automatic int sum_widths(
        input int            cnt,
        input int            bits,
        input logic [4095:0] w
    );
        int s = 0;
        for (int i = 0; i < cnt; i++) begin
            s += int'((w >> (i * bits)) & ~({4096{1'b1}} << bits));
        end
        return s;
    endfunction

endpackage

module rr_trace_unpacker #(
    parameter int LOGB_CHANNEL_CNT      = 2,
    parameter int RR_CHANNEL_WIDTH_BITS = 8,
    parameter logic [LOGB_CHANNEL_CNT*RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = 16'h0804,
    parameter int LOGE_CHANNEL_CNT      = 1,
    parameter int BEAT_WIDTH            = 512,
    localparam int FULL_WIDTH   = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT
                                + rr_trace_pkg::sum_widths(LOGB_CHANNEL_CNT,
                                      RR_CHANNEL_WIDTH_BITS, 4096'(CHANNEL_WIDTHS)),
    localparam int BUF_WIDTH    = FULL_WIDTH + BEAT_WIDTH,
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
    localparam int FILL_WIDTH   = $clog2(BUF_WIDTH + 1),
    localparam int LAST_WIDTH   = $clog2(BEAT_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BEAT_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic [LAST_WIDTH-1:0]   in_last_bits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FULL_WIDTH-1:0]   out_data,
    output logic [OFFSET_WIDTH-1:0] out_len,
    input  logic                    restart,
    output logic                    done,
    output logic                    trunc_err,
    output logic [31:0]             unit_count
);

    localparam int HDR = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    localparam int CW  = RR_CHANNEL_WIDTH_BITS;

    if (BEAT_WIDTH < FULL_WIDTH) begin : g_width_check
        $error("rr_trace_unpacker: BEAT_WIDTH must be >= FULL_WIDTH");
    end

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q;
    logic [BUF_WIDTH-1:0]    sbuf_q;
    logic [FILL_WIDTH-1:0]   fill_q;

    logic [OFFSET_WIDTH-1:0] len;
    logic [FILL_WIDTH-1:0]   len_f;
    logic                    out_fire;
    logic                    in_fire;
    logic [FILL_WIDTH-1:0]   beat_bits;
    logic [BEAT_WIDTH-1:0]   beat_masked;
    logic [FILL_WIDTH-1:0]   consumed;
    logic [FILL_WIDTH-1:0]   fill_rem;
    logic [BUF_WIDTH-1:0]    buf_nxt;
    logic [FILL_WIDTH-1:0]   fill_nxt;

    always_comb begin
        len = OFFSET_WIDTH'(HDR);
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            if (sbuf_q[i]) begin
                len = len + OFFSET_WIDTH'(CHANNEL_WIDTHS[i*CW +: CW]);
            end
        end
    end

    assign len_f     = FILL_WIDTH'(len);
    assign out_valid = (state_q != DONE)
                    && (fill_q >= FILL_WIDTH'(HDR))
                    && (fill_q >= len_f);
    assign out_data  = sbuf_q[FULL_WIDTH-1:0] & ~({FULL_WIDTH{1'b1}} << len);
    assign out_len   = len;
    assign in_ready  = (state_q == RUN) && (fill_q <= FILL_WIDTH'(FULL_WIDTH));

    assign out_fire  = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready;

    // A zero in_last_bits on the last beat means the beat is fully used.
    assign beat_bits = (in_last && (in_last_bits != '0))
                     ? FILL_WIDTH'(in_last_bits)
                     : FILL_WIDTH'(BEAT_WIDTH);
    assign beat_masked = in_data & ~({BEAT_WIDTH{1'b1}} << beat_bits);

    assign consumed = out_fire ? len_f : '0;
    assign fill_rem = fill_q - consumed;
    assign buf_nxt  = (sbuf_q >> consumed)
                    | (in_fire ? (BUF_WIDTH'(beat_masked) << fill_rem) : '0);
    assign fill_nxt = fill_rem + (in_fire ? beat_bits : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RUN;
            sbuf_q     <= '0;
            fill_q     <= '0;
            unit_count <= '0;
            trunc_err  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_fire && (unit_count != '1)) begin
                unit_count <= unit_count + 32'd1;
            end
            unique case (state_q)
                RUN: begin
                    sbuf_q <= buf_nxt;
                    fill_q <= fill_nxt;
                    if (in_fire && in_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fill_q == '0) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else if (!out_valid) begin
                        // Leftover bits cannot form a whole unit.
                        state_q   <= DONE;
                        done      <= 1'b1;
                        trunc_err <= 1'b1;
                        sbuf_q    <= '0;
                        fill_q    <= '0;
                    end else begin
                        sbuf_q <= buf_nxt;
                        fill_q <= fill_nxt;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state_q    <= RUN;
                        sbuf_q     <= '0;
                        fill_q     <= '0;
                        unit_count <= '0;
                        trunc_err  <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_trace_unpacker.sv
// Directed bench for rr_trace_unpacker: LOGB=2 (widths 4,8), LOGE=1,
// FULL_WIDTH=15, BEAT_WIDTH=16.

module tb_rr_trace_unpacker;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [4:0]  in_last_bits = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] out_data;
    logic [3:0]  out_len;
    logic        restart = 1'b0;
    logic        done;
    logic        trunc_err;
    logic [31:0] unit_count;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [18:0] q[$];

    rr_trace_unpacker #(
        .LOGB_CHANNEL_CNT(2),
        .RR_CHANNEL_WIDTH_BITS(8),
        .CHANNEL_WIDTHS(16'h0804),
        .LOGE_CHANNEL_CNT(1),
        .BEAT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_last_bits(in_last_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_len(out_len),
        .restart(restart),
        .done(done),
        .trunc_err(trunc_err),
        .unit_count(unit_count)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view matches the edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) q.push_back({out_len, out_data});
            if (done) done_cnt++;
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        restart = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l,
                             input logic [4:0] lb, input string name);
        bit ok = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        in_last_bits = lb;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s beat not accepted within 200 cycles", name);
        end
    endtask

    task automatic wait_done(input int d0, input string name);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = (done_cnt > d0);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done not seen within 200 cycles", name);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid, in_ready, trunc_err, done} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_flags got %b exp 0100",
                     {out_valid, in_ready, trunc_err, done});
        end
        tests++;
        if (unit_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_count got %0d exp 0", unit_count);
        end
    endtask

    task automatic test_one_beat();
        int q0, d0;
        do_reset();
        out_ready = 1'b1;
        q0 = q.size();
        d0 = done_cnt;
        send_beat(16'hFE55, 1'b1, 5'd10, "one_beat");
        tests++;
        if ({out_valid, out_len, out_data} !== {1'b1, 4'd7, 15'h0055}) begin
            fails++;
            $display("FAIL one_latency got %b/%0d/%h exp 1/7/0055",
                     out_valid, out_len, out_data);
        end
        wait_done(d0, "one_done");
        tests++;
        if (q.size() - q0 != 2) begin
            fails++;
            $display("FAIL one_units got %0d exp 2", q.size() - q0);
        end else begin
            tests++;
            if (q[q0] !== {4'd7, 15'h0055} || q[q0+1] !== {4'd3, 15'h0004}) begin
                fails++;
                $display("FAIL one_data got %h %h exp %h %h", q[q0], q[q0+1],
                         {4'd7, 15'h0055}, {4'd3, 15'h0004});
            end
        end
        tests++;
        if (done_cnt - d0 != 1 || unit_count !== 32'd2 || trunc_err !== 1'b0) begin
            fails++;
            $display("FAIL one_status got pulses %0d count %0d trunc %b exp 1 2 0",
                     done_cnt - d0, unit_count, trunc_err);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_idle got rdy %b vld %b exp 0 0", in_ready, out_valid);
        end
        pulse_restart();
        tests++;
        if (unit_count !== 32'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart_clear got count %0d rdy %b exp 0 1",
                     unit_count, in_ready);
        end
    endtask

    task automatic test_straddle();
        int q0, d0;
        do_reset();
        out_ready = 1'b1;
        q0 = q.size();
        d0 = done_cnt;
        send_beat(16'h6E55, 1'b0, 5'd0, "straddle_b0");
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (q.size() - q0 != 2 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL straddle_wait got units %0d vld %b exp 2 0",
                     q.size() - q0, out_valid);
        end
        send_beat(16'h0169, 1'b1, 5'd9, "straddle_b1");
        tests++;
        if ({out_valid, out_len, out_data} !== {1'b1, 4'd15, 15'h5A5B}) begin
            fails++;
            $display("FAIL straddle_unit got %b/%0d/%h exp 1/15/5a5b",
                     out_valid, out_len, out_data);
        end
        wait_done(d0, "straddle_done");
        tests++;
        if (unit_count !== 32'd3 || trunc_err !== 1'b0) begin
            fails++;
            $display("FAIL straddle_count got %0d trunc %b exp 3 0",
                     unit_count, trunc_err);
        end
    endtask

    task automatic test_backpressure();
        int q0, d0, pos;
        logic [63:0] stream;
        logic [3:0]  lens[8];
        logic [14:0] vals[8];
        lens = '{4'd7, 4'd3, 4'd11, 4'd15, 4'd7, 4'd3, 4'd11, 4'd7};
        vals = '{15'h0055, 15'h0004, 15'h05A6, 15'h5A5B,
                 15'h0031, 15'h0000, 15'h07FE, 15'h007D};
        stream = '0;
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            stream = stream | (64'(vals[i]) << pos);
            pos += int'(lens[i]);
        end
        do_reset();
        q0 = q.size();
        d0 = done_cnt;
        send_beat(stream[15:0], 1'b0, 5'd0, "bp_b0");
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready_drop got %b exp 0", in_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, out_len, out_data} !== {2'b01, 4'd7, 15'h0055}) begin
            fails++;
            $display("FAIL bp_hold got %b%b/%0d/%h exp 01/7/0055",
                     in_ready, out_valid, out_len, out_data);
        end
        out_ready = 1'b1;
        send_beat(stream[31:16], 1'b0, 5'd0, "bp_b1");
        send_beat(stream[47:32], 1'b0, 5'd0, "bp_b2");
        send_beat(stream[63:48], 1'b1, 5'd0, "bp_b3");
        wait_done(d0, "bp_done");
        tests++;
        if (q.size() - q0 != 8) begin
            fails++;
            $display("FAIL bp_units got %0d exp 8", q.size() - q0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (q[q0+i] !== {lens[i], vals[i]}) begin
                    fails++;
                    $display("FAIL bp_unit%0d got %h exp %h", i, q[q0+i],
                             {lens[i], vals[i]});
                end
            end
        end
        tests++;
        if (unit_count !== 32'd8 || trunc_err !== 1'b0) begin
            fails++;
            $display("FAIL bp_count got %0d trunc %b exp 8 0", unit_count, trunc_err);
        end
    endtask

    task automatic test_truncation();
        int q0, d0;
        do_reset();
        out_ready = 1'b1;
        q0 = q.size();
        d0 = done_cnt;
        send_beat(16'h0017, 1'b1, 5'd5, "trunc_beat");
        wait_done(d0, "trunc_done");
        tests++;
        if (trunc_err !== 1'b1 || q.size() != q0 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL trunc_flag got err %b units %0d pulses %0d exp 1 0 1",
                     trunc_err, q.size() - q0, done_cnt - d0);
        end
        pulse_restart();
        tests++;
        if (trunc_err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL trunc_restart got err %b rdy %b exp 0 1", trunc_err, in_ready);
        end
        d0 = done_cnt;
        send_beat(16'h0004, 1'b1, 5'd3, "rerun_beat");
        wait_done(d0, "rerun_done");
        tests++;
        if (unit_count !== 32'd1 || q.size() - q0 != 1 || q[$] !== {4'd3, 15'h0004}) begin
            fails++;
            $display("FAIL rerun got count %0d last %h exp 1 %h",
                     unit_count, q[$], {4'd3, 15'h0004});
        end
    endtask

    task automatic test_restart_ignored();
        do_reset();
        send_beat(16'h0055, 1'b0, 5'd0, "ign_beat");
        pulse_restart();
        tests++;
        if ({out_valid, out_len, out_data} !== {1'b1, 4'd7, 15'h0055}) begin
            fails++;
            $display("FAIL restart_ignored got %b/%0d/%h exp 1/7/0055",
                     out_valid, out_len, out_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_beat(16'h01D5, 1'b1, 5'd9, "ar_beat");
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ar_setup got vld %b exp 1", out_valid);
        end
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, done, trunc_err} !== 4'b0100 || unit_count !== 32'd0) begin
            fails++;
            $display("FAIL ar_async got %b count %0d exp 0100 0",
                     {out_valid, in_ready, done, trunc_err}, unit_count);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL ar_release got rdy %b vld %b exp 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_one_beat();
        test_straddle();
        test_backpressure();
        test_truncation();
        test_restart_ignored();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
